// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and defaults for the round-robin register arbiter.
// Imported by the arbiter top and its picker.
package rr_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        COOL  = 2'b10
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_reg_arbiter_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Returns the winner both one-hot and as a binary index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx
);

    int   j;
    logic found;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbitrated shared register: IDLE -> GRANT -> COOL per write.
// All outputs come straight from flops.
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic              CK,
    input  logic              RN,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      q,
    output logic              busy
);

    localparam int PW = ptr_width(NREQ);

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   widx, widx_n;
    logic [NREQ-1:0] gnt_n;
    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic [W-1:0]    q_n;
    logic [W-1:0]    wsel;
    logic            busy_n;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    // Winner's data slice, only consumed on the GRANT->COOL edge
    always_comb begin
        wsel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (widx == PW'(i)) begin
                wsel = wdata[i*W +: W];
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        widx_n  = widx;
        gnt_n   = gnt;
        q_n     = q;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    gnt_n   = pick_oh;
                    widx_n  = pick_idx;
                end
            end
            GRANT: begin
                state_n = COOL;
                q_n     = wsel;
                gnt_n   = '0;
                ptr_n   = (widx == PW'(NREQ - 1)) ? '0 : widx + PW'(1);
            end
            COOL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            ptr   <= '0;
            widx  <= '0;
            gnt   <= '0;
            q     <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            widx  <= widx_n;
            gnt   <= gnt_n;
            q     <= q_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Self-checking bench for rr_reg_arbiter (NREQ=4, W=8).
// Directed table, corner sequences and random traffic vs a reference model.
module tb_rr_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           CK = 1'b0;
    logic           RN = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           busy;

    int errors = 0;
    int checks = 0;

    rr_reg_arbiter #(
        .NREQ (N),
        .W    (W)
    ) dut (
        .CK    (CK),
        .RN    (RN),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .q     (q),
        .busy  (busy)
    );

    always #5 CK = ~CK;

    // Reference model: a transaction is "winner chosen", then "data written
    // and pointer moved past winner", then one idle-recovery cycle.
    int           m_phase = 0;
    int           m_ptr   = 0;
    int           m_win   = 0;
    logic [N-1:0] m_gnt   = '0;
    logic [W-1:0] m_q     = '0;

    function automatic int rr_first(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            m_phase <= 0;
            m_ptr   <= 0;
            m_win   <= 0;
            m_gnt   <= '0;
            m_q     <= '0;
        end else if (m_phase == 0) begin
            if (req != '0) begin
                m_win   <= rr_first(req, m_ptr);
                m_gnt   <= N'(1) << rr_first(req, m_ptr);
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_q     <= W'(wdata >> (m_win * W));
            m_ptr   <= (m_win + 1) % N;
            m_gnt   <= '0;
            m_phase <= 2;
        end else begin
            m_phase <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CK);
        @(negedge CK);
        chk("model_gnt", 32'(gnt), 32'(m_gnt));
        chk("model_q", 32'(q), 32'(m_q));
        chk("model_busy", 32'(busy), 32'(m_phase != 0));
    endtask

    task automatic pulse_reset();
        RN = 1'b0;
        #2;
        RN = 1'b1;
    endtask

    function automatic int oh_index(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0]   r;
        logic [N*W-1:0] wd;
        logic [N-1:0]   egnt;
        logic [W-1:0]   eq;
    } vec_t;

    vec_t vecs[5];

    int cnt[N];
    int nwin;
    logic [N-1:0] prev;

    initial begin
        vecs[0] = '{4'b0100, 32'h003C_0000, 4'b0100, 8'h3C};
        vecs[1] = '{4'b1001, 32'h1100_0022, 4'b1000, 8'h11};
        vecs[2] = '{4'b1001, 32'h1100_0022, 4'b0001, 8'h22};
        vecs[3] = '{4'b0011, 32'h0000_7E05, 4'b0010, 8'h7E};
        vecs[4] = '{4'b0001, 32'h0000_0099, 4'b0001, 8'h99};

        @(posedge CK);
        @(negedge CK);
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_q", 32'(q), 0);
        chk("reset_busy", 32'(busy), 0);
        RN = 1'b1;

        // Directed single transactions, pointer carried across entries
        for (int i = 0; i < 5; i++) begin
            req   = vecs[i].r;
            wdata = vecs[i].wd;
            cyc();
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].egnt));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 1);
            req = '0;
            cyc();
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].eq));
            chk($sformatf("vec%0d_gntclr", i), 32'(gnt), 0);
            wdata = ~vecs[i].wd;
            cyc();
            chk($sformatf("vec%0d_idle", i), 32'(busy), 0);
            cyc();
            chk($sformatf("vec%0d_qhold", i), 32'(q), 32'(vecs[i].eq));
        end

        // Fairness: all four requesting, 12 transactions from ptr=0
        pulse_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        nwin = 0;
        req = 4'b1111;
        for (int c = 0; c < 36; c++) begin
            wdata = $urandom;
            cyc();
            if (gnt != '0) begin
                chk("fair_order", 32'(oh_index(gnt)), 32'(nwin % N));
                cnt[oh_index(gnt)]++;
                nwin++;
            end
        end
        req = '0;
        chk("fair_total", 32'(nwin), 12);
        for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), 32'(cnt[i]), 3);

        // Single-requester streaming: pulses every 3 cycles, never adjacent
        @(negedge CK);
        pulse_reset();
        req = 4'b0010;
        prev = '0;
        nwin = 0;
        for (int c = 0; c < 15; c++) begin
            cyc();
            chk("stream_adjacent", 32'(prev != '0 && gnt != '0), 0);
            if (gnt != '0) begin
                chk("stream_gnt", 32'(gnt), 32'(4'b0010));
                chk("stream_phase", 32'(c % 3), 0);
                nwin++;
            end
            prev = gnt;
        end
        req = '0;
        chk("stream_count", 32'(nwin), 5);

        // Asynchronous reset in the middle of a GRANT cycle
        @(negedge CK);
        pulse_reset();
        req   = 4'b0001;
        wdata = 32'h0000_00A5;
        cyc();
        req = '0;
        cyc();
        chk("rst_pre_q", 32'(q), 32'hA5);
        cyc();
        req   = 4'b0001;
        wdata = 32'h0000_005A;
        cyc();
        chk("rst_pre_gnt", 32'(gnt), 32'(4'b0001));
        #2;
        RN = 1'b0;
        #1;
        chk("rst_async_q", 32'(q), 0);
        chk("rst_async_gnt", 32'(gnt), 0);
        chk("rst_async_busy", 32'(busy), 0);
        @(negedge CK);
        chk("rst_held_q", 32'(q), 0);
        RN = 1'b1;
        cyc();
        chk("rst_first_gnt", 32'(gnt), 32'(4'b0001));
        req = '0;
        cyc();
        cyc();

        // Random traffic with occasional asynchronous resets
        for (int c = 0; c < 400; c++) begin
            req   = N'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 60) == 0) begin
                #1;
                pulse_reset();
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, meaning width of the shared register.
REQ-003 SHALL have port CK  input  1  rising-edge clock, the block's only clock.
REQ-004 SHALL have port RN  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester write request, level.
REQ-006 SHALL have port wdata  input  NREQ*W  per-requester write data; slice i is bits [i*W +: W].
REQ-007 SHALL have port gnt  output  NREQ  one-hot grant, registered.
REQ-008 SHALL have port q  output  W  shared register contents.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL implement the FSM states IDLE, GRANT and COOL.
REQ-011 IDLE SHALL go to GRANT on the next CK edge when any req bit is 1, and SHALL otherwise stay in IDLE.
REQ-012 On the IDLE->GRANT edge, the block SHALL register gnt as one-hot for the winner, chosen round-robin from the pointer ptr.
REQ-013 The winner SHALL be the first requester with req=1, searching ptr, ptr+1, ... modulo NREQ.
REQ-014 In GRANT, q SHALL load the winner's wdata slice on the next edge, and the FSM SHALL go to COOL.
REQ-015 On the same GRANT->COOL edge, ptr SHALL become (winner+1) mod NREQ.
REQ-016 On the same GRANT->COOL edge, gnt SHALL clear to 0.
REQ-017 gnt SHALL be high for exactly 1 cycle per transaction.
REQ-018 The latency from req sampled to gnt high SHALL be 1 cycle.
REQ-019 The latency from req sampled to q updated SHALL be 2 cycles.
REQ-020 COOL SHALL go to IDLE unconditionally after 1 cycle, so one transaction takes 3 cycles.
REQ-021 A requester SHALL hold req and wdata stable until it sees gnt.
REQ-022 If the winner drops req during GRANT, the write SHALL still complete; a drop is not an abort.
REQ-023 A requester that keeps req high after its grant SHALL compete again, and SHALL lose to any other active requester because of the pointer advance.
REQ-024 When only one requester is active, it SHALL be granted back-to-back, every 3 cycles.
REQ-025 When ptr wraps from NREQ-1, the next ptr SHALL be 0.
REQ-026 q SHALL change only on the GRANT->COOL edge.
REQ-027 Changes on wdata outside GRANT SHALL be ignored.
REQ-028 With NREQ requesters continuously active, each requester SHALL be granted once in every NREQ transactions; this is the starvation bound.

Reset
REQ-029 RN=0 SHALL asynchronously force state=IDLE, ptr=0, gnt=0, q=0 and busy=0, without waiting for a CK edge.
REQ-030 Reset asserted during GRANT SHALL abort the write, leaving q=0 and no grant outstanding.
REQ-031 After RN deasserts, the first possible gnt SHALL come on the first CK edge at which req is nonzero.

Structure
REQ-032 A shared package SHALL hold the state encoding typedef (IDLE=2'b00, GRANT=2'b01, COOL=2'b10) and the default constants NREQ_DEF=4 and W_DEF=8.
REQ-033 One sub-module, rr_pick, SHALL be used: purely combinational, inputs req and ptr, outputs a one-hot winner and its binary index.
REQ-034 All state, ptr, gnt and q SHALL be flops with asynchronous active-low reset on RN.
REQ-035 There SHALL be no latches.
REQ-036 Outputs SHALL be driven directly from flops.

Verification
REQ-037 Scenario reset: RN=0 mid-GRANT with q previously 8'hA5 -> immediately q=0, gnt=0, busy=0; after release, req=4'b0001 -> gnt=4'b0001 one cycle later.
REQ-038 Scenario single request: req=4'b0100, wdata slice2=8'h3C -> gnt=4'b0100 at cycle+1, q=8'h3C at cycle+2, busy low at cycle+3.
REQ-039 Scenario fairness: req=4'b1111 held for 12 transactions starting at ptr=0 -> grant order 0,1,2,3,0,1,2,3,..., each requester granted exactly 3 times.
REQ-040 Scenario wrap: ptr=3 with req=4'b1001 -> requester 3 granted, ptr=0, then requester 0 granted.
REQ-041 Scenario early drop: requester 1 is granted and drops req in GRANT with wdata=8'h7E -> q=8'h7E, no further grant to requester 1.
REQ-042 Scenario single-requester streaming: req=4'b0010 held continuously -> gnt=4'b0010 pulses every 3 cycles, never two consecutive cycles high.
